// File: rtl/vga_sync_capture.sv
// vga_sync_capture: locks to an incoming VGA stream and reports
// per-pixel coordinates, colour and frame markers downstream.
module vga_sync_capture #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    input  logic       vga_hsync,
    input  logic       vga_vsync,
    input  logic [2:0] rgbIn,
    output logic [9:0] PosX,
    output logic [9:0] PosY,
    output logic       pix_valid,
    output logic [2:0] rgbOut,
    output logic       frame_start,
    output logic       locked,
    output logic [7:0] err_cnt
);

    localparam int H_START = H_SYNC + H_BACK;
    localparam int V_START = V_SYNC + V_BACK;

    localparam logic [9:0]  CNT_MAX = 10'd1023;
    localparam logic [10:0] H_LEN   = 11'(H_TOTAL);
    localparam logic [10:0] V_LEN   = 11'(V_TOTAL);
    localparam logic [9:0]  H_END   = 10'(H_TOTAL);
    localparam logic [9:0]  H_LO    = 10'(H_START);
    localparam logic [9:0]  H_HI    = 10'(H_START + H_ACTIVE);
    localparam logic [9:0]  V_LO    = 10'(V_START);
    localparam logic [9:0]  V_HI    = 10'(V_START + V_ACTIVE);

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        LOCKED
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic       hs_q;
    logic       vs_q;
    logic       h_seen;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [9:0] h_nx;
    logic [9:0] v_nx;
    logic       hs_edge;
    logic       vs_edge;
    logic       line_bad;
    logic       frame_bad;
    logic       h_timeout;
    logic       vis;
    logic       fs_nx;
    logic       err_inc;

    assign hs_edge = pix_en & hs_q & ~vga_hsync;
    assign vs_edge = pix_en & vs_q & ~vga_vsync;

    // Post-update counter values; vsync wins over hsync for v_cnt.
    always_comb begin
        h_nx = h_cnt;
        v_nx = v_cnt;
        if (pix_en) begin
            if (hs_edge)
                h_nx = '0;
            else if (h_cnt != CNT_MAX)
                h_nx = h_cnt + 10'd1;
            if (vs_edge)
                v_nx = '0;
            else if (hs_edge && v_cnt != CNT_MAX)
                v_nx = v_cnt + 10'd1;
        end
    end

    assign line_bad  = hs_edge & h_seen &
                       (({1'b0, h_cnt} + 11'd1) != H_LEN);
    assign frame_bad = vs_edge &
                       (({1'b0, v_cnt} + 11'd1) != V_LEN);
    assign h_timeout = pix_en & ~hs_edge & (h_nx == H_END);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= SEARCH;
        else if (pix_en)
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            SEARCH: begin
                if (vs_edge)
                    state_nx = MEASURE;
            end
            MEASURE: begin
                if (line_bad)
                    state_nx = SEARCH;
                else if (vs_edge && !frame_bad)
                    state_nx = LOCKED;
            end
            LOCKED: begin
                if (line_bad || frame_bad || h_timeout)
                    state_nx = SEARCH;
            end
            default: state_nx = SEARCH;
        endcase
    end

    always_comb begin
        vis = pix_en && (state_nx == LOCKED) &&
              (h_nx >= H_LO) && (h_nx < H_HI) &&
              (v_nx >= V_LO) && (v_nx < V_HI);
        fs_nx   = vs_edge && (state_nx == LOCKED);
        err_inc = (state == LOCKED) && (state_nx == SEARCH);
    end

    assign locked = (state == LOCKED);

    // Sync samples idle high so reset never fakes a leading edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            h_cnt  <= '0;
            v_cnt  <= '0;
            h_seen <= 1'b0;
        end else if (pix_en) begin
            hs_q  <= vga_hsync;
            vs_q  <= vga_vsync;
            h_cnt <= h_nx;
            v_cnt <= v_nx;
            if (hs_edge)
                h_seen <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            PosX        <= '0;
            PosY        <= '0;
            rgbOut      <= '0;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            err_cnt     <= '0;
        end else begin
            pix_valid   <= vis;
            frame_start <= fs_nx;
            if (vis) begin
                PosX   <= h_nx - H_LO;
                PosY   <= v_nx - V_LO;
                rgbOut <= rgbIn;
            end
            if (err_inc && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_vga_sync_capture.sv
// Bench for vga_sync_capture on a scaled-down raster: vector table,
// hand sequences and randomized streams against a timestamp model.
module tb_vga_sync_capture;

    localparam int HS  = 2;
    localparam int HB  = 2;
    localparam int HA  = 4;
    localparam int HT  = 10;
    localparam int VS  = 1;
    localparam int VB  = 1;
    localparam int VA  = 3;
    localparam int VT  = 6;
    localparam int HST = HS + HB;
    localparam int VST = VS + VB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pix_en = 1'b0;
    logic       vga_hsync = 1'b1;
    logic       vga_vsync = 1'b1;
    logic [2:0] rgbIn = '0;
    logic [9:0] PosX;
    logic [9:0] PosY;
    logic       pix_valid;
    logic [2:0] rgbOut;
    logic       frame_start;
    logic       locked;
    logic [7:0] err_cnt;

    vga_sync_capture #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_TOTAL(VT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pix_en(pix_en),
        .vga_hsync(vga_hsync),
        .vga_vsync(vga_vsync),
        .rgbIn(rgbIn),
        .PosX(PosX),
        .PosY(PosY),
        .pix_valid(pix_valid),
        .rgbOut(rgbOut),
        .frame_start(frame_start),
        .locked(locked),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: positions from edge timestamps, lock by rules.
    int m_hs, m_vs, m_hseen;
    int m_n, m_t_hs, m_lines, m_mode;
    int e_x, e_y, e_rgb, e_err, e_pv, e_fs;

    int pv_cnt, fs_cnt, first_x, first_y, last_x, last_y;
    int gap_mode, pat, hold;

    typedef struct {
        int sl, dl, xl, hold, after, exp_lock, exp_err;
    } vec_t;
    vec_t vt[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 1023) ? 1023 : v;
    endfunction

    function automatic int pattern(input int px, input int py);
        return 4 * int'(px < 2) + 2 * int'(px > 1 && px < 3) +
               int'(py > 1);
    endfunction

    task automatic model_reset();
        m_hs = 1; m_vs = 1; m_hseen = 0;
        m_n = 0; m_t_hs = -1; m_lines = 0; m_mode = 0;
        e_x = 0; e_y = 0; e_rgb = 0; e_err = 0; e_pv = 0; e_fs = 0;
    endtask

    task automatic model_step(input int en, input int hs,
                              input int vs, input int rgb);
        int he, ve, lbad, fbad, tmo, x, y, len, flen, nm;
        e_pv = 0;
        e_fs = 0;
        if (en == 0) return;
        he   = int'(m_hs == 1 && hs == 0);
        ve   = int'(m_vs == 1 && vs == 0);
        len  = sat(m_n - 1 - m_t_hs) + 1;
        flen = sat(m_lines) + 1;
        x    = (he != 0) ? 0 : sat(m_n - m_t_hs);
        if (ve != 0) m_lines = 0;
        else if (he != 0) m_lines++;
        y    = sat(m_lines);
        lbad = int'(he != 0 && m_hseen != 0 && len != HT);
        fbad = int'(ve != 0 && flen != VT);
        tmo  = int'(he == 0 && x == HT);
        nm   = m_mode;
        case (m_mode)
            0: if (ve != 0) nm = 1;
            1: begin
                if (lbad != 0) nm = 0;
                else if (ve != 0 && fbad == 0) nm = 2;
            end
            default: begin
                if (lbad != 0 || fbad != 0 || tmo != 0) begin
                    nm = 0;
                    if (e_err < 255) e_err++;
                end
            end
        endcase
        m_mode = nm;
        e_fs = int'(ve != 0 && nm == 2);
        if (nm == 2 && x >= HST && x < HST + HA &&
            y >= VST && y < VST + VA) begin
            e_pv = 1;
            e_x = x - HST;
            e_y = y - VST;
            e_rgb = rgb;
        end
        if (he != 0) begin
            m_t_hs = m_n;
            m_hseen = 1;
        end
        m_hs = hs;
        m_vs = vs;
        m_n++;
    endtask

    task automatic check_all();
        chk("locked", int'(locked), int'(m_mode == 2));
        chk("pix_valid", int'(pix_valid), e_pv);
        chk("frame_start", int'(frame_start), e_fs);
        chk("err_cnt", int'(err_cnt), e_err);
        chk("PosX", int'(PosX), e_x);
        chk("PosY", int'(PosY), e_y);
        chk("rgbOut", int'(rgbOut), e_rgb);
    endtask

    task automatic cycle(input logic en, input logic hs,
                         input logic vs, input logic [2:0] rgb);
        @(negedge clk);
        pix_en = en;
        vga_hsync = hs;
        vga_vsync = vs;
        rgbIn = rgb;
        @(posedge clk);
        #1;
        if (!rst) model_reset();
        else model_step(int'(en), int'(hs), int'(vs), int'(rgb));
        check_all();
        if (pix_valid) begin
            if (pv_cnt == 0) begin
                first_x = int'(PosX);
                first_y = int'(PosY);
            end
            last_x = int'(PosX);
            last_y = int'(PosY);
            pv_cnt++;
        end
        if (frame_start) fs_cnt++;
    endtask

    task automatic idle();
        cycle(1'b0, 1'($urandom), 1'($urandom), 3'($urandom));
    endtask

    task automatic gaps();
        case (gap_mode)
            0: idle();
            1: ;
            default: repeat ($urandom_range(0, 2)) idle();
        endcase
    endtask

    task automatic pix(input int x, input int y);
        logic hs;
        int r;
        hs = (x >= HS);
        if (hold > 0) begin
            hs = 1'b1;
            hold--;
        end
        r = (pat != 0) ? pattern(x - HST, y - VST)
                       : int'($urandom_range(0, 7));
        cycle(1'b1, hs, logic'(y >= VS), 3'(r));
    endtask

    task automatic mid_reset();
        chk("pre_rst_posx", int'(PosX), 1);
        chk("pre_rst_posy", int'(PosY), 1);
        #2 rst = 1'b0;
        #1;
        chk("rst_locked", int'(locked), 0);
        chk("rst_pix_valid", int'(pix_valid), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_posx", int'(PosX), 0);
        chk("rst_posy", int'(PosY), 0);
        chk("rst_rgb", int'(rgbOut), 0);
        model_reset();
        repeat (3) idle();
        rst = 1'b1;
        fs_cnt = 0;
    endtask

    task automatic gen_frame(input int sl = -1, input int dl = 0,
                             input int xl = 0, input int rst_y = -1,
                             input int start = 0);
        int k;
        k = 0;
        for (int y = 0; y < VT + xl; y++) begin
            for (int x = 0; x < HT + ((y == sl) ? dl : 0); x++) begin
                if (k >= start) begin
                    gaps();
                    pix(x, y);
                    if (y == rst_y && x == HST + 1) mid_reset();
                end
                k++;
            end
        end
    endtask

    initial begin
        vt[0] = '{-1, 0, 0, 0,    1,  1, 0};
        vt[1] = '{2,  1, 0, 0,    2,  1, 1};
        vt[2] = '{4, -1, 0, 0,    1,  0, 2};
        vt[3] = '{-1, 0, 0, 0,    1,  1, 2};
        vt[4] = '{-1, 0, 1, 0,    3,  1, 3};
        vt[5] = '{-1, 0, 0, 1100, 22, 1, 4};
        vt[6] = '{-1, 0, 0, 0,    1,  1, 4};

        gap_mode = 0;
        pat = 0;
        hold = 0;
        pv_cnt = 0;
        fs_cnt = 0;
        model_reset();
        repeat (3) idle();
        rst = 1'b1;

        // Lock acquisition: second vsync edge, one frame after the first.
        gen_frame();
        chk("acq_locked_early", int'(locked), 0);
        chk("acq_fs_early", fs_cnt, 0);
        gaps();
        pix(0, 0);
        chk("acq_locked", int'(locked), 1);
        chk("acq_fs", int'(frame_start), 1);
        idle();
        chk("acq_fs_pulse", int'(frame_start), 0);
        gen_frame(-1, 0, 0, -1, 1);

        pat = 1;
        pv_cnt = 0;
        gen_frame();
        chk("frame_pv_count", pv_cnt, HA * VA);
        chk("first_x", first_x, 0);
        chk("first_y", first_y, 0);
        chk("last_x", last_x, HA - 1);
        chk("last_y", last_y, VA - 1);
        pat = 0;

        foreach (vt[i]) begin
            hold = vt[i].hold;
            gen_frame(vt[i].sl, vt[i].dl, vt[i].xl);
            repeat (vt[i].after) gen_frame();
            chk($sformatf("vec%0d_locked", i), int'(locked),
                vt[i].exp_lock);
            chk($sformatf("vec%0d_err", i), int'(err_cnt),
                vt[i].exp_err);
        end

        gap_mode = 2;
        for (int r = 0; r < 8; r++) begin
            hold = ($urandom_range(0, 3) == 0) ?
                   int'($urandom_range(1, 80)) : 0;
            gen_frame(int'($urandom_range(0, VT - 1)),
                      int'($urandom_range(0, 2)) - 1,
                      int'($urandom_range(0, 1)), -1,
                      int'($urandom_range(0, 30)));
            repeat (2) gen_frame();
        end

        gap_mode = 0;
        hold = 0;
        repeat (3) gen_frame();
        gen_frame(-1, 0, 0, VST + 1);
        gen_frame();
        chk("post_rst_locked_a", int'(locked), 0);
        chk("post_rst_fs_a", fs_cnt, 0);
        gen_frame();
        chk("post_rst_locked_b", int'(locked), 1);
        chk("post_rst_fs_b", fs_cnt, 1);

        gap_mode = 1;
        for (int i = 0; i < 258; i++) begin
            gen_frame(1, -1);
            gen_frame();
        end
        chk("err_saturate", int'(err_cnt), 255);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
